ise_div_sched: RTL and testbench
================================

// Module: ise_div_sched
// PURPOSE
//  Shared iterative divider with round-robin arbitration for the image sorting engine.
//  Up to NUM_REQ requesters (default R/G/B average units) post {dividend, divisor} pairs.
//  One restoring divider serves them one at a time, replacing per-channel combinational dividers.
//  Produces one quotient, tagged with the requester id, per division.
// PARAMETERS
//  NUM_REQ  3   number of requesters, legal range 2..4
//  DVD_W    30  dividend width (channel total << 8)
//  DSR_W    15  divisor width (channel pixel count)
//  QUO_W    17  quotient width; larger results saturate
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  req        in   NUM_REQ        per-requester request level
//  dvd_flat   in   NUM_REQ*DVD_W  dividends, requester i at [i*DVD_W +: DVD_W]
//  dsr_flat   in   NUM_REQ*DSR_W  divisors, requester i at [i*DSR_W +: DSR_W]
//  ack        out  NUM_REQ        one-hot, 1-cycle pulse: operands of requester i captured
//  busy       out  1              high when state != IDLE
//  res_valid  out  1              1-cycle pulse: result outputs are valid
//  res_id     out  2              requester index of the current result
//  res_quo    out  QUO_W          quotient
//  res_dz     out  1              divisor was zero
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; RR pointer NUM_REQ-1, so req[0] has first priority.
//  FSM states and transitions:
//   IDLE: if any req, pick first set bit from (ptr+1) mod NUM_REQ upward, wrapping.
//         Latch that requester's operands; ptr <= winner.
//         Divisor 0 -> DONE; otherwise -> CALC with cnt=0.
//   CALC: restoring division, one quotient bit per cycle, MSB first, for DVD_W cycles.
//         Partial remainder is DSR_W+1 bits. After cnt==DVD_W-1 -> DONE.
//   DONE: res_valid=1 for one cycle -> IDLE.
//  Handshake:
//   - ack[winner] is registered; high for the one cycle following the capture edge.
//   - Requester holds req and operands stable until it samples ack=1, then drops req.
//   - req is ignored outside IDLE. req still high on return to IDLE is treated as a new request.
//  Latency: res_valid is high DVD_W+1 edges after the capture edge (dz case: 1 edge).
//   Back-to-back throughput is one result per DVD_W+2 cycles.
//  Result outputs: res_quo, res_id and res_dz hold their value until the next DONE.
//  Arithmetic:
//   - Full quotient is DVD_W bits wide.
//   - Any set bit above QUO_W-1 -> res_quo = all ones (saturate).
//   - dz: res_quo = all ones, res_dz = 1.
//  Boundary conditions:
//   - Simultaneous requests: served strictly round-robin; no requester waits more than NUM_REQ-1 divisions.
//   - A request arriving during CALC or DONE waits in IDLE arbitration.
//   - Reset mid-CALC: in-flight division discarded; no res_valid or ack emitted; ptr returns to NUM_REQ-1.
// CONFIGURATION
//  ISE_DIV_ROUND_EN defined:
//   - Dividend is replaced by dividend + (divisor>>1) before division.
//   - Addition is done DVD_W+1 bits wide; CALC runs DVD_W+1 cycles; latency becomes DVD_W+2.
//   - Result is round-to-nearest, ties up.
//  ISE_DIV_ROUND_EN undefined: truncating division; timing exactly as above.
// TESTING
//  1. req[0], dvd=256000, dsr=4 -> ack[0] 1 edge after capture; res_valid 31 edges after capture;
//     res_quo=64000, res_id=0, res_dz=0.
//  2. req=3'b111 right after reset, each re-raised after its result -> results in id order 0,1,2,0,1,2.
//     Each operand set returns its own quotient.
//  3. req[1], dsr=0 -> res_valid 1 edge after capture; res_quo=17'h1FFFF, res_dz=1, res_id=1.
//  4. req[2], dvd=2**29, dsr=1 -> res_quo=17'h1FFFF (saturated), res_dz=0.
//  5. dvd=7, dsr=2 -> res_quo=3 without ISE_DIV_ROUND_EN; res_quo=4 with it.
//  6. reset pulsed 10 cycles into CALC -> busy=0, no res_valid or ack; next req[0] served with normal latency.

Source files
------------

// File: rtl/ise_div_sched_if.sv
// ise_div_sched_if: request/result bundle of the shared divider.
// master = requester side, slave = divider side.
interface ise_div_sched_if #(
    parameter int NUM_REQ = 3,
    parameter int DVD_W   = 30,
    parameter int DSR_W   = 15,
    parameter int QUO_W   = 17
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*DVD_W-1:0] dvd_flat;
    logic [NUM_REQ*DSR_W-1:0] dsr_flat;
    logic [NUM_REQ-1:0]       ack;
    logic                     busy;
    logic                     res_valid;
    logic [1:0]               res_id;
    logic [QUO_W-1:0]         res_quo;
    logic                     res_dz;

    modport master (
        output req,
        output dvd_flat,
        output dsr_flat,
        input  ack,
        input  busy,
        input  res_valid,
        input  res_id,
        input  res_quo,
        input  res_dz
    );

    modport slave (
        input  req,
        input  dvd_flat,
        input  dsr_flat,
        output ack,
        output busy,
        output res_valid,
        output res_id,
        output res_quo,
        output res_dz
    );
endinterface

// File: rtl/ise_div_sched.sv
// ise_div_sched: round-robin shared restoring divider, one quotient bit/cycle.
// Define ISE_DIV_ROUND_EN for round-to-nearest (ties up) instead of truncation.
module ise_div_sched #(
    parameter int NUM_REQ = 3,
    parameter int DVD_W   = 30,
    parameter int DSR_W   = 15,
    parameter int QUO_W   = 17
) (
    input  logic           clk,
    input  logic           reset,
    ise_div_sched_if.slave bus
);
`ifdef ISE_DIV_ROUND_EN
    localparam int NB = DVD_W + 1;
`else
    localparam int NB = DVD_W;
`endif
    localparam int CW = $clog2(NB) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         cur_q, cur_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NB-1:0]      work_q, work_d;
    logic [DSR_W-1:0]   rem_q, rem_d;
    logic [DSR_W-1:0]   dsr_q, dsr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [1:0]         rid_q, rid_d;
    logic [QUO_W-1:0]   quo_q, quo_d;
    logic               dz_q, dz_d;

    logic               any_req;
    logic [1:0]         win;
    logic [DVD_W-1:0]   sel_dvd;
    logic [DSR_W-1:0]   sel_dsr;
    logic [NB-1:0]      sel_ext;
    logic [DSR_W:0]     shf;
    logic               ge;
    logic [NB-1:0]      q_full;
    logic               sat;
    logic               last;
    logic               busy_c;
    logic               rv_c;

    // Round-robin pick: first pending requester after ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win     = ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                win     = 2'(idx);
            end
        end
    end

    // Operand mux for the winner, optionally biased by half the divisor.
    always_comb begin
        sel_dvd = bus.dvd_flat[int'(win)*DVD_W +: DVD_W];
        sel_dsr = bus.dsr_flat[int'(win)*DSR_W +: DSR_W];
`ifdef ISE_DIV_ROUND_EN
        sel_ext = NB'(sel_dvd) + NB'(sel_dsr >> 1);
`else
        sel_ext = sel_dvd;
`endif
    end

    // One restoring step; shf is the DSR_W+1 bit partial remainder.
    always_comb begin
        shf    = {rem_q, work_q[NB-1]};
        ge     = shf >= {1'b0, dsr_q};
        q_full = {work_q[NB-2:0], ge};
        sat    = |q_full[NB-1:QUO_W];
        last   = cnt_q == CW'(NB - 1);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = (sel_dsr == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture, iterate, publish result.
    always_comb begin
        ptr_d  = ptr_q;
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        work_d = work_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        ack_d  = '0;
        rid_d  = rid_q;
        quo_d  = quo_q;
        dz_d   = dz_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    ptr_d  = win;
                    cur_d  = win;
                    ack_d  = NUM_REQ'(1) << win;
                    work_d = sel_ext;
                    rem_d  = '0;
                    dsr_d  = sel_dsr;
                    cnt_d  = '0;
                    if (sel_dsr == '0) begin
                        rid_d = win;
                        quo_d = '1;
                        dz_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                work_d = q_full;
                rem_d  = ge ? DSR_W'(shf - {1'b0, dsr_q})
                            : shf[DSR_W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    rid_d = cur_q;
                    dz_d  = 1'b0;
                    quo_d = sat ? '1 : q_full[QUO_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any in-flight division.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= 2'(NUM_REQ - 1);
            cur_q  <= '0;
            cnt_q  <= '0;
            work_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            ack_q  <= '0;
            rid_q  <= '0;
            quo_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            ack_q  <= ack_d;
            rid_q  <= rid_d;
            quo_q  <= quo_d;
            dz_q   <= dz_d;
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy_c = state_q != IDLE;
        rv_c   = state_q == DONE;
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_c;
    assign bus.res_valid = rv_c;
    assign bus.res_id    = rid_q;
    assign bus.res_quo   = quo_q;
    assign bus.res_dz    = dz_q;

endmodule

// File: tb/tb_ise_div_sched.sv
// tb_ise_div_sched: directed + random requests vs. arithmetic/RR model.
// Build with ISE_DIV_ROUND_EN to check the rounding variant.
module tb_ise_div_sched;
    localparam int NR = 3;
    localparam int DW = 30;
    localparam int SW = 15;
    localparam int QW = 17;
`ifdef ISE_DIV_ROUND_EN
    localparam int NB  = DW + 1;
    localparam bit RND = 1'b1;
`else
    localparam int NB  = DW;
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ise_div_sched_if #(
        .NUM_REQ(NR), .DVD_W(DW), .DSR_W(SW), .QUO_W(QW)
    ) bif ();

    ise_div_sched #(
        .NUM_REQ(NR), .DVD_W(DW), .DSR_W(SW), .QUO_W(QW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    logic [NR-1:0] req = '0;
    logic [DW-1:0] dvd [NR];
    logic [SW-1:0] dsr [NR];

    always_comb begin
        bif.req      = req;
        bif.dvd_flat = '0;
        bif.dsr_flat = '0;
        for (int i = 0; i < NR; i++) begin
            bif.dvd_flat[i*DW +: DW] = dvd[i];
            bif.dsr_flat[i*SW +: SW] = dsr[i];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model state
    int            mptr = NR - 1;
    bit            inflight = 0;
    int            fl_id, fl_k, fl_lat;
    logic [QW-1:0] fl_quo;
    bit            fl_dz;
    bit            have_last = 0;
    logic [QW-1:0] last_quo;
    int            last_id;
    bit            last_dz;
    int            rearm [NR];
    bit            auto_raise = 0;
    int            results = 0;
    int            target = 0;
    int            order [$];

    function automatic logic [QW-1:0] ref_quo(logic [DW-1:0] a, logic [SW-1:0] b);
        longint unsigned n, q, lim;
        lim = (64'd1 << QW) - 1;
        if (b == 0) return '1;
        n = a;
        if (RND) n += b / 2;
        q = n / b;
        if (q > lim) return '1;
        return QW'(q);
    endfunction

    function automatic int ref_win(logic [NR-1:0] m, int p);
        for (int k = 1; k <= NR; k++)
            if (m[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic logic [SW-1:0] rand_dsr();
        int s = $urandom_range(0, 9);
        if (s == 0) return '0;
        if (s == 1) return SW'($urandom_range(1, 3));
        return SW'($urandom_range(1, (1 << SW) - 1));
    endfunction

    function automatic logic [DW-1:0] rand_dvd();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 1000));
        return DW'($urandom());
    endfunction

    task automatic raise(int i, logic [DW-1:0] a, logic [SW-1:0] b);
        dvd[i] = a;
        dsr[i] = b;
        req[i] = 1'b1;
    endtask

    task automatic step();
        int w;
        @(posedge clk);
        #1;
        if (inflight) fl_k++;
        if (bif.ack != '0) begin
            w = ref_win(req, mptr);
            check("ack_win", 64'(bif.ack), (w < 0) ? 64'd0 : (64'd1 << w));
            check("ack_free", 64'(inflight), 64'd0);
            check("ack_busy", 64'(bif.busy), 64'd1);
            if (have_last && !bif.res_valid) begin
                check("hold_quo", 64'(bif.res_quo), 64'(last_quo));
                check("hold_id", 64'(bif.res_id), 64'(last_id));
                check("hold_dz", 64'(bif.res_dz), 64'(last_dz));
            end
            if (w >= 0) begin
                mptr     = w;
                inflight = 1;
                fl_id    = w;
                fl_dz    = (dsr[w] == 0);
                fl_quo   = ref_quo(dvd[w], dsr[w]);
                fl_lat   = fl_dz ? 1 : NB + 1;
                fl_k     = 1;
                req[w]   = 1'b0;
            end
        end
        if (bif.res_valid) begin
            check("rv_expected", 64'(inflight), 64'd1);
            if (inflight) begin
                check("latency", 64'(fl_k), 64'(fl_lat));
                check("res_id", 64'(bif.res_id), 64'(fl_id));
                check("res_quo", 64'(bif.res_quo), 64'(fl_quo));
                check("res_dz", 64'(bif.res_dz), 64'(fl_dz));
                inflight  = 0;
                have_last = 1;
                last_quo  = bif.res_quo;
                last_id   = int'(bif.res_id);
                last_dz   = bif.res_dz;
                order.push_back(fl_id);
                results++;
                if (rearm[fl_id] > 0) begin
                    rearm[fl_id]--;
                    raise(fl_id, rand_dvd(), rand_dsr());
                end
            end
        end
        if (auto_raise && results >= target) auto_raise = 0;
        if (auto_raise) begin
            for (int i = 0; i < NR; i++)
                if (!req[i] && !(inflight && fl_id == i) &&
                    $urandom_range(0, 7) == 0)
                    raise(i, rand_dvd(), rand_dsr());
        end
    endtask

    task automatic run(int budget);
        int c = 0;
        while ((req != '0 || inflight || auto_raise) && c < budget) begin
            step();
            c++;
        end
        check("run_done", 64'(req == '0 && !inflight && !auto_raise), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        mptr      = NR - 1;
        inflight  = 0;
        have_last = 0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < NR; i++) begin
            dvd[i]   = '0;
            dsr[i]   = '0;
            rearm[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(bif.ack), 64'd0);
        check("rst_busy", 64'(bif.busy), 64'd0);
        check("rst_rv", 64'(bif.res_valid), 64'd0);
        check("rst_quo", 64'(bif.res_quo), 64'd0);
        check("rst_id", 64'(bif.res_id), 64'd0);
        check("rst_dz", 64'(bif.res_dz), 64'd0);
        reset = 1'b0;

        // 1: plain division
        raise(0, DW'(256000), SW'(4));
        run(100);
        check("t1_quo", 64'(last_quo), 64'd64000);
        check("t1_id", 64'(last_id), 64'd0);

        // 3: divide by zero
        raise(1, DW'(12345), SW'(0));
        run(20);
        check("t3_quo", 64'(last_quo), 64'h1FFFF);
        check("t3_dz", 64'(last_dz), 64'd1);
        check("t3_id", 64'(last_id), 64'd1);

        // 4: saturation
        raise(2, DW'(1) << 29, SW'(1));
        run(100);
        check("t4_quo", 64'(last_quo), 64'h1FFFF);
        check("t4_dz", 64'(last_dz), 64'd0);

        // 5: rounding behaviour
        raise(0, DW'(7), SW'(2));
        run(100);
        check("t5_quo", 64'(last_quo), RND ? 64'd4 : 64'd3);

        // 6: reset 10 cycles into CALC
        raise(0, rand_dvd(), SW'($urandom_range(1, 100)));
        c = 0;
        while (!(inflight && fl_k >= 11) && c < 50) begin
            step();
            c++;
        end
        check("t6_reach", 64'(inflight && fl_k >= 11), 64'd1);
        reset = 1'b1;
        req   = '0;
        #1;
        check("t6_busy", 64'(bif.busy), 64'd0);
        check("t6_rv", 64'(bif.res_valid), 64'd0);
        check("t6_ack", 64'(bif.ack), 64'd0);
        do_reset();
        repeat (40) step();
        order.delete();
        raise(0, rand_dvd(), rand_dsr());
        raise(2, rand_dvd(), rand_dsr());
        run(200);
        check("t6_n", 64'(order.size()), 64'd2);
        if (order.size() == 2) check("t6_first", 64'(order[0]), 64'd0);

        // 2: all three requesting right after reset, re-raised once
        do_reset();
        order.delete();
        for (int i = 0; i < NR; i++) begin
            rearm[i] = 1;
            raise(i, rand_dvd(), rand_dsr());
        end
        run(400);
        check("t2_n", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size() && i < 6; i++)
            check("t2_order", 64'(order[i]), 64'(i % NR));

        // random traffic
        target     = results + 60;
        auto_raise = 1;
        run(60 * (NB + 2) + 500);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
